// File: rtl/eth_tx_feeder.sv
// eth_tx_feeder: splits payload bytes into low/high nibbles for the MII transmit FIFO, then starts the MAC sender and holds the inter-frame gap.
// Define ETH_TX_PAD_EN to zero-pad short frames to MIN_BYTES.
module eth_tx_feeder #(
`ifdef ETH_TX_PAD_EN
    parameter int MIN_BYTES  = 46,
`endif
    parameter int MAX_BYTES  = 1500,
    parameter int IFG_CYCLES = 24
) (
    input  logic        mii_tx_clk,
    input  logic        rst_n,
    input  logic        pkt_valid,
    input  logic [7:0]  pkt_data,
    input  logic        pkt_last,
    input  logic [15:0] pkt_type,
    output logic        pkt_ready,
    output logic        fifo_wrreq,
    output logic [3:0]  fifo_wrdata,
    input  logic        fifo_wrfull,
    output logic        tx_go,
    output logic [11:0] data_length,
    output logic [15:0] type_length,
    input  logic        send_done,
    output logic        busy,
    output logic        ovf_err
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_HI   = 3'd1;
    localparam logic [2:0] LOAD_LO   = 3'd2;
`ifdef ETH_TX_PAD_EN
    localparam logic [2:0] PAD_LO    = 3'd3;
    localparam logic [2:0] PAD_HI    = 3'd4;
`endif
    localparam logic [2:0] GO        = 3'd5;
    localparam logic [2:0] WAIT_DONE = 3'd6;
    localparam logic [2:0] GAP       = 3'd7;
    localparam int GW = $clog2(IFG_CYCLES + 1);
    localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

    logic [2:0]    state;
    logic [10:0]   byte_cnt;
    logic [10:0]   cnt_inc;
    logic [3:0]    hi_nib;
    logic [15:0]   type_q;
    logic [GW-1:0] gap_cnt;
    logic          last_q;
    logic          ovf;
    logic          sd_q;
    logic          first_wait;
    logic          accept;
    logic          at_max;
    logic [2:0]    eof_state;

    assign pkt_ready = rst_n && (state == IDLE || state == LOAD_LO) && !fifo_wrfull;
    assign busy      = state != IDLE;
    assign accept    = pkt_valid && pkt_ready;
    assign at_max    = state == LOAD_LO && byte_cnt == MAX_CNT;
    assign cnt_inc   = byte_cnt + 11'd1;
`ifdef ETH_TX_PAD_EN
    assign eof_state = cnt_inc < 11'(MIN_BYTES) ? PAD_LO : GO;
`else
    assign eof_state = GO;
`endif

    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            hi_nib      <= '0;
            type_q      <= '0;
            gap_cnt     <= '0;
            last_q      <= 1'b0;
            ovf         <= 1'b0;
            sd_q        <= 1'b0;
            first_wait  <= 1'b0;
            fifo_wrreq  <= 1'b0;
            fifo_wrdata <= '0;
            tx_go       <= 1'b0;
            data_length <= '0;
            type_length <= '0;
            ovf_err     <= 1'b0;
        end else begin
            fifo_wrreq <= 1'b0;
            tx_go      <= 1'b0;
            ovf_err    <= 1'b0;
            sd_q       <= send_done;
            case (state)
                IDLE, LOAD_LO: begin
                    if (accept) begin
                        if (state == IDLE) begin
                            type_q   <= pkt_type;
                            byte_cnt <= '0;
                            ovf      <= 1'b0;
                        end
                        // bytes past MAX_BYTES are swallowed so the user stream never stalls
                        if (at_max) begin
                            ovf <= 1'b1;
                            if (pkt_last)
                                state <= GO;
                        end else begin
                            fifo_wrreq  <= 1'b1;
                            fifo_wrdata <= pkt_data[3:0];
                            hi_nib      <= pkt_data[7:4];
                            last_q      <= pkt_last;
                            state       <= LOAD_HI;
                        end
                    end
                end
                LOAD_HI: begin
                    if (!fifo_wrfull) begin
                        fifo_wrreq  <= 1'b1;
                        fifo_wrdata <= hi_nib;
                        byte_cnt    <= cnt_inc;
                        state       <= last_q ? eof_state : LOAD_LO;
                    end
                end
`ifdef ETH_TX_PAD_EN
                PAD_LO: begin
                    if (!fifo_wrfull) begin
                        fifo_wrreq  <= 1'b1;
                        fifo_wrdata <= 4'h0;
                        state       <= PAD_HI;
                    end
                end
                PAD_HI: begin
                    if (!fifo_wrfull) begin
                        fifo_wrreq  <= 1'b1;
                        fifo_wrdata <= 4'h0;
                        byte_cnt    <= cnt_inc;
                        state       <= eof_state;
                    end
                end
`endif
                GO: begin
                    tx_go       <= 1'b1;
                    data_length <= {byte_cnt, 1'b0};
                    type_length <= type_q;
                    ovf_err     <= ovf;
                    first_wait  <= 1'b1;
                    state       <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    first_wait <= 1'b0;
                    if (!first_wait && send_done && !sd_q) begin
                        gap_cnt <= GW'(IFG_CYCLES);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_feeder.sv
// tb_eth_tx_feeder: directed frames against eth_tx_feeder with a nibble scoreboard.
// Expected lengths follow ETH_TX_PAD_EN when the bench is built with it.
module tb_eth_tx_feeder;
    localparam int MAX_BYTES = 1500;
    localparam int IFG       = 24;
`ifdef ETH_TX_PAD_EN
    localparam int MIN_BYTES = 46;
`endif

    logic        mii_tx_clk  = 1'b0;
    logic        rst_n       = 1'b0;
    logic        pkt_valid   = 1'b0;
    logic [7:0]  pkt_data    = 8'h00;
    logic        pkt_last    = 1'b0;
    logic [15:0] pkt_type    = 16'h0000;
    logic        fifo_wrfull = 1'b0;
    logic        send_done   = 1'b0;
    logic        pkt_ready;
    logic        fifo_wrreq;
    logic [3:0]  fifo_wrdata;
    logic        tx_go;
    logic [11:0] data_length;
    logic [15:0] type_length;
    logic        busy;
    logic        ovf_err;

    always #20 mii_tx_clk = ~mii_tx_clk;

    eth_tx_feeder dut (
        .mii_tx_clk (mii_tx_clk),
        .rst_n      (rst_n),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_last   (pkt_last),
        .pkt_type   (pkt_type),
        .pkt_ready  (pkt_ready),
        .fifo_wrreq (fifo_wrreq),
        .fifo_wrdata(fifo_wrdata),
        .fifo_wrfull(fifo_wrfull),
        .tx_go      (tx_go),
        .data_length(data_length),
        .type_length(type_length),
        .send_done  (send_done),
        .busy       (busy),
        .ovf_err    (ovf_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  wr_q[$];
    logic [3:0]  exp_q[$];
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          go_cnt = 0;
    int          go_cyc = 0;
    int          go_lat = 0;
    int          stray_ovf = 0;
    logic [11:0] go_len = '0;
    logic [15:0] go_type = '0;
    logic        go_ovf = 1'b0;

    always @(negedge mii_tx_clk) begin
        cyc++;
        if (fifo_wrreq) begin
            wr_q.push_back(fifo_wrdata);
            last_wr_cyc = cyc;
        end
        if (tx_go) begin
            go_cnt++;
            go_cyc  = cyc;
            go_lat  = cyc - last_wr_cyc;
            go_len  = data_length;
            go_type = type_length;
            go_ovf  = ovf_err;
        end
        if (ovf_err && !tx_go)
            stray_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic build_exp(input int n, input logic [7:0] seed);
        logic [7:0] b;
        int bytes;
        exp_q.delete();
        bytes = n > MAX_BYTES ? MAX_BYTES : n;
        for (int i = 0; i < bytes; i++) begin
            b = seed + 8'(i);
            exp_q.push_back(b[3:0]);
            exp_q.push_back(b[7:4]);
        end
`ifdef ETH_TX_PAD_EN
        for (int i = bytes; i < MIN_BYTES; i++) begin
            exp_q.push_back(4'h0);
            exp_q.push_back(4'h0);
        end
`endif
    endtask

    function automatic int exp_len(input int n);
        int bytes;
        bytes = n > MAX_BYTES ? MAX_BYTES : n;
`ifdef ETH_TX_PAD_EN
        if (bytes < MIN_BYTES)
            bytes = MIN_BYTES;
`endif
        return 2 * bytes;
    endfunction

    task automatic check_fifo(input string tag);
        int errs = 0;
        int n;
        check({tag, "_nibbles"}, wr_q.size(), exp_q.size());
        n = wr_q.size() < exp_q.size() ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (wr_q[i] !== exp_q[i])
                errs++;
        check({tag, "_order"}, errs, 0);
    endtask

    task automatic send_frame(input int n, input logic [15:0] typ, input logic [7:0] seed);
        logic r;
        int t;
        for (int i = 0; i < n; i++) begin
            pkt_valid = 1'b1;
            pkt_data  = seed + 8'(i);
            pkt_last  = (i == n - 1);
            pkt_type  = typ;
            t = 0;
            do begin
                #2 r = pkt_ready;
                @(posedge mii_tx_clk);
                @(negedge mii_tx_clk);
                t++;
            end while (!r && t < 300);
            if (!r) begin
                check("accept_timeout", 0, 1);
                i = n;
            end
        end
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
    endtask

    task automatic wait_go(input int target);
        int t = 0;
        while (go_cnt < target && t < 4000) begin
            @(negedge mii_tx_clk);
            #1 t++;
        end
        check("tx_go_seen", go_cnt, target);
    endtask

    task automatic finish_frame(input string tag);
        int t = 0;
        repeat (2) @(negedge mii_tx_clk);
        send_done = 1'b1;
        @(negedge mii_tx_clk);
        send_done = 1'b0;
        while (busy && t < 200) begin
            @(negedge mii_tx_clk);
            #1 t++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #(40 * 40000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sd_cyc;
        #5;
        check("rst_busy", busy, 0);
        check("rst_ready", pkt_ready, 0);
        check("rst_wrreq", fifo_wrreq, 0);
        check("rst_tx_go", tx_go, 0);
        check("rst_len", data_length, 0);
        check("rst_type", type_length, 0);
        check("rst_ovf", ovf_err, 0);
        repeat (2) @(negedge mii_tx_clk);
        rst_n = 1'b1;
        #1 check("ready_after_rst", pkt_ready, 1);

        // 64-byte frame, no padding needed
        build_exp(64, 8'h00);
        wr_q.delete();
        send_frame(64, 16'h0800, 8'h00);
        wait_go(1);
        check_fifo("f64");
        check("f64_len", go_len, 128);
        check("f64_type", go_type, 16'h0800);
        check("f64_ovf", go_ovf, 0);
        check("f64_latency", go_lat, 1);
        check("f64_busy", busy, 1);
        finish_frame("f64");
        check("f64_len_stable", data_length, 128);

        // 10-byte frame: padded to 92 nibbles or left at 20
        build_exp(10, 8'hA0);
        wr_q.delete();
        send_frame(10, 16'h0042, 8'hA0);
        wait_go(2);
        check_fifo("f10");
        check("f10_len", go_len, exp_len(10));
        check("f10_type", go_type, 16'h0042);
        finish_frame("f10");

        // 1502 bytes: two dropped, overflow flagged at tx_go
        build_exp(1502, 8'h00);
        wr_q.delete();
        send_frame(1502, 16'h05DC, 8'h00);
        wait_go(3);
        check_fifo("f1502");
        check("f1502_len", go_len, 3000);
        check("f1502_ovf", go_ovf, 1);
        finish_frame("f1502");

        // 20-byte frame with a 5-cycle FIFO-full stall in the middle
        build_exp(20, 8'h30);
        wr_q.delete();
        fork
            send_frame(20, 16'h0806, 8'h30);
            begin
                int t = 0;
                int w0, w1;
                int rdy_hi = 0;
                while (wr_q.size() < 10 && t < 500) begin
                    @(negedge mii_tx_clk);
                    #1 t++;
                end
                @(negedge mii_tx_clk);
                fifo_wrfull = 1'b1;
                @(posedge mii_tx_clk);
                #1 w0 = wr_q.size();
                for (int k = 0; k < 5; k++) begin
                    if (pkt_ready)
                        rdy_hi++;
                    if (k < 4) begin
                        @(posedge mii_tx_clk);
                        #1;
                    end
                end
                @(negedge mii_tx_clk);
                #1 w1 = wr_q.size();
                fifo_wrfull = 1'b0;
                check("stall_ready_low", rdy_hi, 0);
                check("stall_no_writes", w1 - w0, 0);
            end
        join
        wait_go(4);
        check_fifo("stall");
        check("stall_len", go_len, exp_len(20));
        check("stall_ovf_cleared", go_ovf, 0);

        // send_done held 3 cycles; a queued frame waits out the gap
        build_exp(8, 8'h10);
        repeat (2) @(negedge mii_tx_clk);
        #1 sd_cyc = cyc;
        wr_q.delete();
        send_done = 1'b1;
        fork
            begin
                repeat (3) @(negedge mii_tx_clk);
                send_done = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge mii_tx_clk);
                    #1 n++;
                end while (!pkt_ready && n < 100);
                check("ifg_ready_cycles", n, IFG + 1);
            end
            send_frame(8, 16'h86DD, 8'h10);
        join
        send_done = 1'b1;
        wait_go(5);
        check("ifg_go_after_gap", (go_cyc - sd_cyc) > IFG, 1);
        check_fifo("f8");
        check("f8_len", go_len, exp_len(8));
        check("f8_type", go_type, 16'h86DD);
        repeat (20) @(negedge mii_tx_clk);
        #1 check("stale_done_ignored", busy, 1);
        send_done = 1'b0;
        finish_frame("f8");

        // asynchronous reset while in LOAD_HI
        @(negedge mii_tx_clk);
        pkt_valid = 1'b1;
        pkt_data  = 8'h5A;
        pkt_last  = 1'b0;
        pkt_type  = 16'h1234;
        @(posedge mii_tx_clk);
        @(negedge mii_tx_clk);
        pkt_valid = 1'b0;
        #1 check("pre_rst_load_hi", {fifo_wrreq, pkt_ready, busy}, 3'b101);
        #5 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_wrreq", fifo_wrreq, 0);
        check("arst_wrdata", fifo_wrdata, 0);
        check("arst_len", data_length, 0);
        check("arst_type", type_length, 0);
        check("arst_ready", pkt_ready, 0);
        @(negedge mii_tx_clk);
        rst_n = 1'b1;
        #1 wr_q.delete();
        build_exp(4, 8'hC0);
        send_frame(4, 16'h88B5, 8'hC0);
        wait_go(6);
        check_fifo("post_rst");
        check("post_rst_len", go_len, exp_len(4));
        check("post_rst_type", go_type, 16'h88B5);
        check("post_rst_ovf", go_ovf, 0);
        finish_frame("post_rst");

        check("ovf_only_with_go", stray_ovf, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
